// File: rtl/skew_feed_db_if.sv
// Bundles the write, stream-control and skewed-output signals of skew_feed_db.
interface skew_feed_db_if #(
  parameter int BITS = 8,
  parameter int DIM  = 8
);
  localparam int IDXBITS = $clog2(DIM);

  logic                          wr_en;
  logic                          wr_col;
  logic [IDXBITS-1:0]            wr_idx;
  logic [DIM-1:0][BITS-1:0]      wr_data;
  logic                          wr_commit;
  logic                          wr_ready;
  logic                          start;
  logic                          en;
  logic [DIM-1:0][BITS-1:0]      out_data;
  logic                          out_valid;
  logic                          done;

  // Producer/controller side
  modport master (
    output wr_en, wr_col, wr_idx, wr_data, wr_commit, start, en,
    input  wr_ready, out_data, out_valid, done
  );

  // Feeder side
  modport slave (
    input  wr_en, wr_col, wr_idx, wr_data, wr_commit, start, en,
    output wr_ready, out_data, out_valid, done
  );
endinterface

// File: rtl/skew_feed_db.sv
// Double-buffered skewed operand feeder: two DIM x DIM banks, loaded by row or
// column, one bank streamed diagonally (lane r lags lane 0 by r cycles) while
// the other is refilled.
module skew_feed_db #(
  parameter int BITS = 8,
  parameter int DIM  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  skew_feed_db_if.slave bus
);
  localparam int IDXBITS = $clog2(DIM);
  localparam int CNTBITS = $clog2(3*DIM-2);
  localparam logic [CNTBITS-1:0] K_LAST = CNTBITS'(3*DIM-3);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNTBITS-1:0]   k_q, k_d;
  logic [1:0]           full_q, full_d;
  logic                 wp_q, wp_d;
  logic                 rp_q, rp_d;
  logic                 done_q, done_d;
  logic                 wr_fire;
  logic [IDXBITS-1:0]   col;

  logic signed [BITS-1:0] bank_q [2][DIM][DIM];

  assign wr_fire       = bus.wr_en && !full_q[wp_q];
  assign bus.wr_ready  = !full_q[wp_q];
  assign bus.out_valid = (state_q == STREAM);
  assign bus.done      = done_q;

  // Bank storage: row or column write into the write bank when it is not full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned r = 0; r < DIM; r++)
          for (int unsigned c = 0; c < DIM; c++)
            bank_q[b][r][c] <= '0;
    end else if (wr_fire) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        if (bus.wr_col) bank_q[wp_q][j][bus.wr_idx] <= bus.wr_data[j];
        else            bank_q[wp_q][bus.wr_idx][j] <= bus.wr_data[j];
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      full_q  <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      full_q  <= full_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      done_q  <= done_d;
    end
  end

  // Next-state: commit on the write side and stream sequencing on the read
  // side; a commit and a stream completion on the same edge touch different
  // full bits, so both apply independently.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    full_d  = full_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    done_d  = 1'b0;

    if (bus.wr_commit && !full_q[wp_q]) begin
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start && full_q[rp_q]) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (bus.en) begin
          if (k_q == K_LAST) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
            state_d      = IDLE;
            k_d          = '0;
            done_d       = 1'b1;
          end else begin
            k_d = k_q + CNTBITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skewed output: lane r shows bank[rp][r][k-r] while that column is in range
  always_comb begin
    bus.out_data = '0;
    col          = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      if ((state_q == STREAM) && (32'(k_q) >= r) &&
          ((32'(k_q) - r) < 32'(DIM))) begin
        col             = IDXBITS'(32'(k_q) - r);
        bus.out_data[r] = bank_q[rp_q][r][col];
      end
    end
  end
endmodule

// File: tb/tb_skew_feed_db.sv
// Directed self-checking bench for skew_feed_db at DIM=4, BITS=8.
module tb_skew_feed_db;
  localparam int BITS = 8;
  localparam int DIM  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  skew_feed_db_if #(.BITS(BITS), .DIM(DIM)) bus();

  skew_feed_db #(.BITS(BITS), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Lane 0 in the low byte
  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put_line(input logic c, input int idx, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_col  = c;
    bus.wr_idx  = 2'(idx);
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Element (line i, lane j): row mode = mul*i+j+add, column mode = mul*j+i+add
  task automatic load(input logic c, input int mul, input int add, input int sgn);
    int e [4];
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++)
        e[j] = sgn * (c ? (mul*j + i + add) : (mul*i + j + add));
      put_line(c, i, pk(e[0], e[1], e[2], e[3]));
    end
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
  endtask

  task automatic stream(input string tag, input logic [31:0] e0, input logic [31:0] e2,
                        input logic [31:0] e3, input logic [31:0] e6, input int exp_len);
    int len;
    len       = -1;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) begin
        len = n;
        break;
      end
      if (n == 0) begin
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_k0"}, bus.out_data, e0);
      end
      if (n == 2) chk({tag, "_k2"}, bus.out_data, e2);
      if (n == 3) chk({tag, "_k3"}, bus.out_data, e3);
      if (n == 6) chk({tag, "_k6"}, bus.out_data, e6);
      if (n == 9) chk({tag, "_k9"}, bus.out_data, 32'h0);
      step();
    end
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_out"}, bus.out_data, 32'h0);
    step();
    chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cnt;
    bus.wr_en = 1'b0; bus.wr_col = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.wr_commit = 1'b0; bus.start = 1'b0; bus.en = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", bus.out_data, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Row load, stream bank0
    load(1'b0, 4, 1, 1);
    chk("row_ready_pre", 32'(bus.wr_ready), 32'd1);
    commit();
    chk("row_ready_post", 32'(bus.wr_ready), 32'd1);
    stream("row", pk(1,0,0,0), pk(3,6,9,0), pk(4,7,10,13), pk(0,0,0,16), 10);
    chk("row_ready_end", 32'(bus.wr_ready), 32'd1);

    // Start with no full bank is ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("nofull_valid0", 32'(bus.out_valid), 32'd0);
    step();
    chk("nofull_valid1", 32'(bus.out_valid), 32'd0);

    // Column load into bank1 gives the same sequence
    load(1'b1, 4, 1, 1);
    commit();
    stream("col", pk(1,0,0,0), pk(3,6,9,0), pk(4,7,10,13), pk(0,0,0,16), 10);

    // Ping-pong: stream bank0 while filling bank1 with -1..-16
    load(1'b0, 4, 1, 1);
    commit();
    bus.en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("pp_k0", bus.out_data, pk(1,0,0,0));
    for (int i = 0; i < 4; i++)
      put_line(1'b0, i, pk(-(4*i+1), -(4*i+2), -(4*i+3), -(4*i+4)));
    commit();
    chk("pp_ready_full", 32'(bus.wr_ready), 32'd0);
    chk("pp_k5", bus.out_data, pk(0,0,12,15));
    // Commit with both full, write to the full bank, start mid-stream: all ignored
    bus.wr_commit = 1'b1; bus.wr_en = 1'b1; bus.wr_col = 1'b0; bus.wr_idx = 2'd3;
    bus.wr_data = pk(99,99,99,99); bus.start = 1'b1;
    step();
    bus.wr_commit = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
    chk("pp_k6_dropped", bus.out_data, pk(0,0,0,16));
    chk("pp_k6_valid", 32'(bus.out_valid), 32'd1);
    step(); step(); step();
    chk("pp_k9", bus.out_data, 32'h0);
    step();
    chk("pp_done", 32'(bus.done), 32'd1);
    chk("pp_done_valid", 32'(bus.out_valid), 32'd0);
    chk("pp_done_ready", 32'(bus.wr_ready), 32'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("pp_b1_done_clr", 32'(bus.done), 32'd0);
    chk("pp_b1_valid", 32'(bus.out_valid), 32'd1);
    chk("pp_b1_k0", bus.out_data, pk(-1,0,0,0));
    step(); step();
    chk("pp_b1_k2", bus.out_data, pk(-3,-6,-9,0));
    step();
    chk("pp_b1_k3", bus.out_data, pk(-4,-7,-10,-13));
    step(); step(); step();
    chk("pp_b1_k6", bus.out_data, pk(0,0,0,-16));
    cnt = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.done) begin
        cnt = n + 1;
        break;
      end
    end
    chk("pp_b1_tail", cnt, 4);
    step();

    // Stall for 3 cycles at k=2
    load(1'b0, 4, 1, 1);
    commit();
    bus.en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    chk("stall_k2", bus.out_data, pk(3,6,9,0));
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", bus.out_data, pk(3,6,9,0));
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.en = 1'b1;
    cnt = -1;
    for (int n = 6; n < 40; n++) begin
      step();
      if (bus.done) begin
        cnt = n;
        break;
      end
    end
    chk("stall_len", cnt, 13);
    step();
    chk("stall_done_once", 32'(bus.done), 32'd0);

    // Reset mid-stream at k=5 (bank1 holds -1..-16)
    load(1'b0, 4, 1, -1);
    commit();
    bus.en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step(); step(); step();
    chk("mid_k5", bus.out_data, pk(0,0,-12,-15));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", bus.out_data, 32'h0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    load(1'b0, 10, 20, 1);
    commit();
    stream("post_rst", pk(20,0,0,0), pk(22,31,40,0), pk(23,32,41,50), pk(0,0,0,53), 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
